// File: rtl/param_bank_pkg.sv
// rtl/param_bank_pkg.sv - shared FSM encoding and default geometry for param_bank
package param_bank_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 12;
  localparam int DEF_DEPTH = 4;

  // -1.0 in Q4.12
  localparam logic [DEF_WIDTH-1:0] DEF_INIT_VAL = 16'hF000;

endpackage

// File: rtl/param_bank_sat_add.sv
// rtl/param_bank_sat_add.sv - signed adder; saturates with PARAM_BANK_SAT_EN, wraps otherwise
module sat_add
  import param_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH:0] w_sum;

  // One guard bit: overflow iff the guard and the result sign disagree
  assign w_sum = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
  assign o_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

`ifdef PARAM_BANK_SAT_EN
  always_comb begin
    o_sum = w_sum[WIDTH-1:0];
    if (o_ovf) begin
      o_sum = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign o_sum = w_sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/param_bank.sv
// rtl/param_bank.sv - signed parameter store with init sweep and delta updates; PARAM_BANK_SAT_EN selects saturation
module param_bank
  import param_bank_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               FRAC     = DEF_FRAC,
  parameter int               DEPTH    = DEF_DEPTH,
  parameter logic [WIDTH-1:0] INIT_VAL = DEF_INIT_VAL
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_start,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [$clog2(DEPTH)-1:0]   upd_addr,
  input  logic [WIDTH-1:0]           upd_delta,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data,
  output logic [DEPTH*WIDTH-1:0]     params_flat,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam int unused_frac = FRAC;

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_entries [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_upd_acc;

  assign upd_ready = (r_state == ST_IDLE) && !init_start;
  assign w_upd_acc = upd_valid && upd_ready;
  assign busy      = (r_state == ST_INIT);
  assign rd_data   = r_rd_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign params_flat[g*WIDTH +: WIDTH] = r_entries[g];
  end

  sat_add #(
    .WIDTH (WIDTH)
  ) u_sat_add (
    .i_a   (r_entries[upd_addr]),
    .i_b   (upd_delta),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      r_rd_data <= r_entries[rd_addr];
      case (r_state)
        ST_IDLE: begin
          if (init_start) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
          end else if (w_upd_acc) begin
            r_entries[upd_addr] <= w_sum;
          end
        end
        ST_INIT: begin
          // A repeated request rewinds the sweep without writing this cycle
          if (init_start) begin
            r_idx <= '0;
          end else begin
            r_entries[r_idx] <= INIT_VAL;
            r_idx            <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

`ifdef PARAM_BANK_SAT_EN
  logic r_sat_flag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sat_flag <= 1'b0;
    end else if (init_start) begin
      r_sat_flag <= 1'b0;
    end else if (w_upd_acc && w_ovf) begin
      r_sat_flag <= 1'b1;
    end
  end

  assign sat_flag = r_sat_flag;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
  assign sat_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_param_bank.sv
// tb/tb_param_bank.sv - directed self-checking bench for param_bank (default geometry)
module tb_param_bank;

  logic        clk;
  logic        reset;
  logic        init_start;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_addr;
  logic [15:0] upd_delta;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic [63:0] params_flat;
  logic        busy;
  logic        sat_flag;

  int checks;
  int failures;

  param_bank dut (
    .clk         (clk),
    .reset       (reset),
    .init_start  (init_start),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_addr    (upd_addr),
    .upd_delta   (upd_delta),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .params_flat (params_flat),
    .busy        (busy),
    .sat_flag    (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] entry(input int k);
    return params_flat[k*16 +: 16];
  endfunction

  logic [15:0] exp_e0;
  logic [15:0] exp_e3;
  logic        exp_sat;

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    init_start = 1'b0;
    upd_valid  = 1'b0;
    upd_addr   = 2'd0;
    upd_delta  = 16'h0000;
    rd_addr    = 2'd0;

    // Reset state
    tick();
    tick();
    check_eq("rst_flat", params_flat, 64'h0);
    check_eq("rst_rd", rd_data, 64'h0);
    check_eq("rst_busy", busy, 64'h0);
    check_eq("rst_ready", upd_ready, 64'h1);
    check_eq("rst_sat", sat_flag, 64'h0);
    reset = 1'b1;

    // Init sweep: busy for exactly 4 cycles, one entry per cycle
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("init_busy%0d", k), busy, 64'h1);
      check_eq($sformatf("init_ready%0d", k), upd_ready, 64'h0);
      tick();
      check_eq($sformatf("init_entry%0d", k), entry(k), 64'hF000);
      if (k < 3) check_eq($sformatf("init_next%0d", k), entry(k + 1), 64'h0);
    end
    check_eq("init_done_busy", busy, 64'h0);
    check_eq("init_flat", params_flat, 64'hF000_F000_F000_F000);

    // Update with same-cycle read of the same entry
    upd_valid = 1'b1;
    upd_addr  = 2'd2;
    upd_delta = 16'h0800;
    rd_addr   = 2'd2;
    tick();
    upd_valid = 1'b0;
    check_eq("upd_entry2", entry(2), 64'hF800);
    check_eq("upd_rd_pre", rd_data, 64'hF000);
    tick();
    check_eq("upd_rd_post", rd_data, 64'hF800);

    // Back-to-back updates bring entry0 to 0x7000 without overflow
    upd_valid = 1'b1;
    upd_addr  = 2'd0;
    upd_delta = 16'h7FFF;
    tick();
    upd_delta = 16'h0001;
    tick();
    upd_valid = 1'b0;
    check_eq("b2b_entry0", entry(0), 64'h7000);
    check_eq("b2b_sat", sat_flag, 64'h0);

    // Held-off update: upd_valid low leaves entries unchanged
    upd_delta = 16'h1234;
    tick();
    check_eq("idle_flat", params_flat, 64'hF000_F800_F000_7000);

`ifdef PARAM_BANK_SAT_EN
    exp_e0  = 16'h7FFF;
    exp_e3  = 16'h8000;
    exp_sat = 1'b1;
`else
    exp_e0  = 16'h9000;
    exp_e3  = 16'h7000;
    exp_sat = 1'b0;
`endif

    // Positive overflow on entry0
    upd_valid = 1'b1;
    upd_addr  = 2'd0;
    upd_delta = 16'h2000;
    tick();
    upd_valid = 1'b0;
    check_eq("ovf_pos_entry0", entry(0), {48'h0, exp_e0});
    check_eq("ovf_pos_sat", sat_flag, {63'h0, exp_sat});

    // Negative overflow on entry3
    upd_valid = 1'b1;
    upd_addr  = 2'd3;
    upd_delta = 16'h8000;
    tick();
    upd_valid = 1'b0;
    check_eq("ovf_neg_entry3", entry(3), {48'h0, exp_e3});
    check_eq("ovf_neg_sat", sat_flag, {63'h0, exp_sat});

    // init_start beats a simultaneous update
    init_start = 1'b1;
    upd_valid  = 1'b1;
    upd_addr   = 2'd1;
    upd_delta  = 16'h0100;
    #1;
    check_eq("coll_ready", upd_ready, 64'h0);
    tick();
    init_start = 1'b0;
    upd_valid  = 1'b0;
    check_eq("coll_busy", busy, 64'h1);
    check_eq("coll_entry1", entry(1), 64'hF000);
    check_eq("coll_sat_clr", sat_flag, 64'h0);
    tick();
    check_eq("coll_entry0", entry(0), 64'hF000);

    // Reset in the second sweep cycle aborts the sweep
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("abort_flat", params_flat, 64'h0);
    check_eq("abort_busy", busy, 64'h0);
    check_eq("abort_rd", rd_data, 64'h0);
    check_eq("abort_ready", upd_ready, 64'h1);

    // Restart mid-sweep rewinds to index 0
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    tick();
    check_eq("rs_entry0", entry(0), 64'hF000);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    check_eq("rs_entry1", entry(1), 64'h0);
    check_eq("rs_busy", busy, 64'h1);
    for (int k = 0; k < 3; k++) tick();
    check_eq("rs_busy_tail", busy, 64'h1);
    tick();
    check_eq("rs_done_busy", busy, 64'h0);
    check_eq("rs_flat", params_flat, 64'hF000_F000_F000_F000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
